regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register file between two writeback requesters.
  - Requester A is ALU writeback.
  - Requester B is load/memory writeback.
- Round-robin arbitration; each request uses a valid/ready handshake.
- Drives a one-hot per-register enable vector plus shared write data, feeding the enable/d inputs of the 32 neg-edge register instances.
- Updates on the rising edge of clk, so enables and data are stable when registers capture on the falling edge.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- NREGS, 32, number of registers. Must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; block state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  pipeline stall; while high no request is granted.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  A granted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  B granted this cycle (combinational).
- wr_en  output  NREGS  registered one-hot register enables.
- wr_data  output  DATA_W  registered write data, shared by all registers.
- wr_addr  output  ADDR_W  registered address of the current write (debug/forwarding).
- last_grant  output  1  0 = A won the most recent grant, 1 = B won.

Behaviour:
- Clock and reset:
  - One clock domain: clk. reset is asynchronous and active-high.
  - While reset is high: wr_en=0, wr_data=0, wr_addr=0, last_grant=1 (so A has priority first), a_ready=0, b_ready=0.
- Transfer rule: a transfer happens on a rising edge where valid && ready.
  - Requesters must hold valid, addr and data stable until they see ready.
- Grant logic (combinational, computed from current inputs and last_grant):
  - If reset or hold is high: both ready outputs are 0.
  - Else if only one valid is high: that requester gets ready=1.
  - Else if both are valid: grant A when last_grant=1, grant B when last_grant=0.
  - a_ready and b_ready are never high in the same cycle.
- last_grant: updates on every transfer to the winner. It holds its value when there is no transfer.
- Output stage, updated each rising edge:
  - On a transfer: wr_addr and wr_data take the winner's addr and data; wr_en = one-hot(addr).
  - If addr==0: wr_en=0, because r0 is hardwired zero. The handshake still completes and wr_addr is still updated.
  - With no transfer: wr_en=0. wr_data and wr_addr hold their values.
- Latency and throughput:
  - A transfer at rising edge N gives wr_en high from edge N to edge N+1.
  - The register captures at the intervening falling edge.
  - One write per cycle maximum. Each enable pulse lasts exactly one cycle.
- Same-address conflict: both requesters targeting one register are serialized in round-robin order; the later write wins in the register file.
- hold asserted mid-stream: no grant that cycle. An output pulse already registered still completes its single cycle.
- Reset mid-operation: any pending wr_en pulse is cleared immediately (asynchronously). Requests are not remembered.
- Invariant: popcount(wr_en) <= 1 at all times.

Test Plan:
- Reset and idle: assert reset with a_valid=1 -> a_ready=0, wr_en=0. Release reset -> next edge wr_en=32'h0000_0004 for a_addr=2, a_data=32'hDEAD_BEEF; wr_data=32'hDEAD_BEEF.
- Single requester streaming: b_valid=1 for 3 cycles with addr 5,6,7 -> b_ready=1 each cycle; wr_en is 0x20, 0x40, 0x80 on consecutive cycles; last_grant=1.
- Contention after reset: A(addr 3, 0x11) and B(addr 4, 0x22) valid together and held -> cycle 1 A granted, wr_en=0x08; cycle 2 B granted, wr_en=0x10, wr_data=0x22.
- Same-address conflict: both target addr 9 with last_grant=0, A=0xAAAA, B=0xBBBB -> B first, then A. The register r9 reads 0xAAAA afterwards.
- Write to r0: a_addr=0, a_valid=1 -> a_ready=1, wr_en stays 0, wr_addr=0.
- Hold and async reset: hold=1 for 2 cycles with both valid -> no ready, wr_en=0. Then assert reset mid-cycle while wr_en=0x100 -> wr_en drops to 0 before the next edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the 32 x 32-bit register file between two
// writeback sources: requester A (ALU writeback) and requester B (load/memory
// writeback). Arbitration is round-robin with a valid/ready handshake per
// requester.
//
// The output stage updates on the rising edge of clk. The register instances
// capture on the falling edge, so wr_en and wr_data are stable for half a
// cycle before the capture point.
//
// Ports
//   clk         system clock, state updates on the rising edge
//   reset       asynchronous, active-high reset
//   hold        pipeline stall; no grant is issued while high
//   a_valid     requester A has a write pending
//   a_addr      requester A destination register
//   a_data      requester A write data
//   a_ready     A granted this cycle (combinational)
//   b_valid     requester B has a write pending
//   b_addr      requester B destination register
//   b_data      requester B write data
//   b_ready     B granted this cycle (combinational)
//   wr_en       registered one-hot register enables (bit 0 never set)
//   wr_data     registered write data, shared by all registers
//   wr_addr     registered address of the current write
//   last_grant  0 = A won the most recent grant, 1 = B won
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [NREGS-1:0]  wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_grant
);

    localparam logic [NREGS-1:0] ONE_HOT_BASE = {{(NREGS-1){1'b0}}, 1'b1};

    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREGS-1:0]  win_en;

    // Round-robin: with both requesters valid, the one that did not win the
    // last grant goes first. last_grant resets to 1 so A has priority first.
    // reset is folded in so ready is low while reset is asserted, even though
    // the flops already hold their reset values.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !hold) begin
            if (a_valid && b_valid) begin
                grant_a = last_grant;
                grant_b = !last_grant;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Winner mux and address decode. r0 is hardwired zero, so address 0
    // completes the handshake but never raises an enable.
    always_comb begin
        win_addr = grant_b ? b_addr : a_addr;
        win_data = grant_b ? b_data : a_data;
        win_en   = '0;
        if (win_addr != '0) begin
            win_en = ONE_HOT_BASE << win_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= '0;
            wr_data    <= '0;
            wr_addr    <= '0;
            last_grant <= 1'b1;
        end else if (grant_a || grant_b) begin
            wr_en      <= win_en;
            wr_data    <= win_data;
            wr_addr    <= win_addr;
            last_grant <= grant_b;
        end else begin
            // Each enable pulse lasts exactly one cycle; data/addr hold.
            wr_en      <= '0;
        end
    end

endmodule
